// File: rtl/uart_rx_fifo_wb.sv
// Receive-side FIFO for the UART: captures each new receiver byte and serves it over a Wishbone classic slave.
// Optional macro UART_RX_FIFO_THRESH_EN adds a programmable interrupt threshold written through register 3.
module uart_rx_fifo_wb #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_dout,
  input  logic       rx_valid,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_COUNT  = 2'd3;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  valid_q, overflow_q, overflow_d, irq_en_q, irq_en_d;
  logic                  ack_q, irq_q, irq_d;
  logic [7:0]            dat_q, dat_d, rdata_s, status_s;
  logic                  access_s, rd_s, wr_s, empty_s, full_s, push_s, pop_s;
  logic                  flush_s, push_ok_s, ovf_set_s, ovf_clr_s;
`ifdef UART_RX_FIFO_THRESH_EN
  logic [7:0]            thresh_q, thresh_d;
`else
  logic                  unused_s;
  assign unused_s = ^wb_dat_i[7:3];
`endif

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign irq      = irq_q;

  // Bus decode and FIFO event qualification
  always_comb begin
    access_s  = wb_cyc_i & wb_stb_i & ~ack_q;
    rd_s      = access_s & ~wb_we_i;
    wr_s      = access_s & wb_we_i;
    empty_s   = (count_q == CNT_ZERO);
    full_s    = (count_q == CNT_FULL);
    push_s    = rx_valid & ~valid_q;
    pop_s     = rd_s & (wb_adr_i == ADR_DATA) & ~empty_s;
    flush_s   = wr_s & (wb_adr_i == ADR_CTRL) & wb_dat_i[1];
    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted
    push_ok_s = push_s & ~flush_s & (~full_s | pop_s);
    ovf_set_s = push_s & ~flush_s & full_s & ~pop_s;
    ovf_clr_s = wr_s & (wb_adr_i == ADR_STATUS) & wb_dat_i[2];
  end

  // Read data mux, sampled from pre-edge state
  always_comb begin
`ifdef UART_RX_FIFO_THRESH_EN
    status_s = {thresh_q[7:3], overflow_q, full_s, ~empty_s};
`else
    status_s = {5'b00000, overflow_q, full_s, ~empty_s};
`endif
    case (wb_adr_i)
      ADR_DATA:   rdata_s = empty_s ? 8'h00 : mem_q[rd_ptr_q];
      ADR_STATUS: rdata_s = status_s;
      ADR_CTRL:   rdata_s = {7'b0000000, irq_en_q};
      ADR_COUNT:  rdata_s = 8'(count_q);
      default:    rdata_s = 8'h00;
    endcase
  end

  // Next-state for pointers, count, flags, bus data and interrupt
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    dat_d      = dat_q;
    if (flush_s) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (wr_s && (wb_adr_i == ADR_CTRL)) begin
      irq_en_d = wb_dat_i[0];
    end else begin
      irq_en_d = irq_en_q;
    end
    if (access_s) begin
      dat_d = wb_we_i ? 8'h00 : rdata_s;
    end else begin
      dat_d = dat_q;
    end
`ifdef UART_RX_FIFO_THRESH_EN
    if (wr_s && (wb_adr_i == ADR_COUNT)) begin
      thresh_d = wb_dat_i;
    end else begin
      thresh_d = thresh_q;
    end
    irq_d = irq_en_q & (((9'(count_q) >= {1'b0, thresh_q}) & (thresh_q != 8'h00)) | overflow_q);
`else
    irq_d = irq_en_q & (~empty_s | overflow_q);
`endif
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b1;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 8'h00;
      irq_q      <= 1'b0;
`ifdef UART_RX_FIFO_THRESH_EN
      thresh_q   <= 8'h01;
`endif
    end else begin
      valid_q    <= rx_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      ack_q      <= access_s;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
`ifdef UART_RX_FIFO_THRESH_EN
      thresh_q   <= thresh_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= rx_dout;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_wb.sv
// Scoreboard bench for uart_rx_fifo_wb: bytes pushed into a model queue, popped and compared on DATA reads.
module tb_uart_rx_fifo_wb;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_dout;
  logic       rx_valid;
  logic       wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbq[$];
  logic       exp_ovf = 1'b0;

  uart_rx_fifo_wb #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .rx_dout(rx_dout), .rx_valid(rx_valid),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output logic [7:0] data);
    logic got_ack = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        got_ack = 1'b1;
        data = wb_dat_o;
        break;
      end
    end
    check_val("ack_seen", {31'd0, got_ack}, 32'd1);
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat);
    logic [7:0] dummy;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = dat;
    wait_ack(dummy);
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [7:0] data);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    wait_ack(data);
  endtask

  task automatic read_check(input string tag, input logic [1:0] adr, input logic [7:0] exp);
    logic [7:0] d;
    wb_read(adr, d);
    check_val(tag, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic read_data_check();
    logic [7:0] d, exp;
    exp = (sbq.size() > 0) ? sbq.pop_front() : 8'h00;
    wb_read(2'd0, d);
    check_val("data", {24'd0, d}, {24'd0, exp});
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk) rx_valid = 1'b0;
    @(negedge clk) rx_dout = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    if (sbq.size() < DEPTH) sbq.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  // DATA read whose ack edge coincides with a receiver push
  task automatic read_with_push(input logic [7:0] b);
    logic [7:0] d, exp;
    @(negedge clk) rx_valid = 1'b0;
    @(negedge clk);
    rx_dout = b; rx_valid = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd0;
    exp = (sbq.size() > 0) ? sbq.pop_front() : 8'h00;
    sbq.push_back(b);
    wait_ack(d);
    check_val("data_push_same_edge", {24'd0, d}, {24'd0, exp});
  endtask

  task automatic wait_irq(input string tag, input logic exp, input int cycles);
    logic seen = ~exp;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      seen = irq;
      if (seen == exp) break;
    end
    check_val(tag, {31'd0, seen}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b1; rx_dout = 8'h00;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 2'd0; wb_dat_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check_val("rst_dat", {24'd0, wb_dat_o}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    read_check("count_after_rst", 2'd3, 8'h00);
    read_check("status_after_rst", 2'd1, 8'h00);
    check_val("irq_after_rst", {31'd0, irq}, 32'd0);

    // Two bytes, then an empty read
    rx_push(8'hA5);
    rx_push(8'h3C);
    read_check("count_two", 2'd3, 8'h02);
    read_data_check();
    read_data_check();
    read_data_check();
    read_check("count_empty", 2'd3, 8'h00);

    // Overfill by one
    for (int i = 0; i < 17; i++) rx_push(8'(i));
    check_val("model_ovf", {31'd0, exp_ovf}, 32'd1);
    read_check("status_full_ovf", 2'd1, 8'h07);
    read_check("count_full", 2'd3, 8'h10);
    for (int i = 0; i < 16; i++) read_data_check();
    wb_write(2'd1, 8'h04);
    exp_ovf = 1'b0;
    read_check("status_cleared", 2'd1, 8'h00);

    // Full FIFO, push on the pop edge
    for (int i = 0; i < 16; i++) rx_push(8'h20 + 8'(i));
    read_with_push(8'h80);
    read_check("count_stays_full", 2'd3, 8'h10);
    read_check("status_no_ovf", 2'd1, 8'h03);
    for (int i = 0; i < 16; i++) read_data_check();
    read_check("count_drained", 2'd3, 8'h00);

    // Interrupt enable and flush
    wb_write(2'd2, 8'h01);
    rx_push(8'h55);
    wait_irq("irq_on_push", 1'b1, 2);
    wb_write(2'd2, 8'h03);
    sbq.delete();
    read_check("count_flushed", 2'd3, 8'h00);
    wait_irq("irq_after_flush", 1'b0, 2);
    read_check("ctrl_readback", 2'd2, 8'h01);

    // Mixed random pushes and reads against the scoreboard
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) rx_push(8'($urandom_range(0, 255)));
      else read_data_check();
    end
    wb_write(2'd2, 8'h02);
    sbq.delete();

`ifdef UART_RX_FIFO_THRESH_EN
    wb_write(2'd3, 8'h03);
    wb_write(2'd2, 8'h01);
    read_check("count_ignores_thresh", 2'd3, 8'h00);
    rx_push(8'h01);
    rx_push(8'h02);
    wait_irq("irq_below_thresh", 1'b0, 2);
    rx_push(8'h03);
    wait_irq("irq_at_thresh", 1'b1, 2);
    read_data_check();
    wait_irq("irq_after_read", 1'b0, 2);
`endif

    // Reset in the middle of an acknowledged cycle
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd1;
    @(posedge clk); #1;
    check_val("ack_before_abort", {31'd0, wb_ack_o}, 32'd1);
    rst = 1'b1; #1;
    check_val("ack_aborted", {31'd0, wb_ack_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk) rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
